// File: rtl/sparce_sasa_cfg_ctrl.sv
// SparCE SASA table configuration sequencer: buffers software config writes and replays them
// onto the table write port, with a hardware clear sweep. Optional macro SPARCE_CFG_ADDR_CHECK_EN.
module sparce_sasa_cfg_ctrl #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          NUM_ENTRIES  = 16,
    parameter logic [31:0] SASA_BASE    = 32'h0000_1000,
    parameter int          ENTRY_STRIDE = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cfg_wen,
    input  logic [31:0] cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_ready,
    input  logic        clear_req,
    output logic        clear_busy,
    input  logic        skipping,
    output logic        sasa_wen,
    output logic [31:0] sasa_addr,
    output logic [31:0] sasa_data,
    output logic        idle,
    output logic        cfg_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [31:0]      STRIDE_W = 32'(ENTRY_STRIDE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    logic [31:0]      fifo_addr_r [FIFO_DEPTH];
    logic [31:0]      fifo_data_r [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    state_t           state_r;
    state_t           state_nx_s;
    logic             clear_pend_r;
    logic [IDX_W-1:0] sweep_idx_r;
    logic             sasa_wen_r;
    logic [31:0]      sasa_addr_r;
    logic [31:0]      sasa_data_r;

    logic             empty_s;
    logic             full_s;
    logic             cfg_ready_s;
    logic             addr_ok_s;
    logic             push_s;
    logic             pop_s;
    logic             sweep_wr_s;
    logic             sweep_done_s;
    logic             clear_acc_s;
    logic [31:0]      sweep_addr_s;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_s      = (wr_ptr_r == rd_ptr_r);
    assign full_s       = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                          (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign cfg_ready_s  = !full_s && !clear_pend_r;
    assign push_s       = cfg_wen && cfg_ready_s && addr_ok_s;
    assign clear_acc_s  = clear_req && !clear_pend_r;
    assign sweep_addr_s = SASA_BASE + (32'(sweep_idx_r) * STRIDE_W) + 32'd4;

    assign cfg_ready  = cfg_ready_s;
    assign clear_busy = clear_pend_r;
    assign sasa_wen   = sasa_wen_r;
    assign sasa_addr  = sasa_addr_r;
    assign sasa_data  = sasa_data_r;
    assign idle       = empty_s && !clear_pend_r && (state_r == ST_IDLE) && !sasa_wen_r;

`ifdef SPARCE_CFG_ADDR_CHECK_EN
    localparam logic [31:0] SASA_END = SASA_BASE + 32'(NUM_ENTRIES * ENTRY_STRIDE);

    function automatic logic addr_valid(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= SASA_BASE) && (addr < SASA_END);
    endfunction

    logic cfg_err_r;

    assign addr_ok_s = addr_valid(cfg_addr);
    assign cfg_err   = cfg_err_r;

    // Sticky error: a new bad write wins over a simultaneous clear acceptance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cfg_err_r <= 1'b0;
        end else if (cfg_wen && cfg_ready_s && !addr_ok_s) begin
            cfg_err_r <= 1'b1;
        end else if (clear_acc_s) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_err_r;
        end
    end
`else
    assign addr_ok_s = 1'b1;
    assign cfg_err   = 1'b0;
`endif

    // Next-state and per-cycle pop/sweep decisions; IDLE pops immediately to hit two-cycle latency.
    always_comb begin
        state_nx_s   = state_r;
        pop_s        = 1'b0;
        sweep_wr_s   = 1'b0;
        sweep_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_pend_r && empty_s) begin
                    state_nx_s = ST_CLEAR;
                end else if (!empty_s) begin
                    state_nx_s = ST_DRAIN;
                    pop_s      = !skipping;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (empty_s) begin
                    state_nx_s = clear_pend_r ? ST_CLEAR : ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                    pop_s      = !skipping;
                end
            end
            ST_CLEAR: begin
                if (!skipping) begin
                    sweep_wr_s = 1'b1;
                    if (sweep_idx_r == LAST_IDX) begin
                        sweep_done_s = 1'b1;
                        state_nx_s   = ST_IDLE;
                    end else begin
                        state_nx_s = ST_CLEAR;
                    end
                end else begin
                    state_nx_s = ST_CLEAR;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Write buffer storage and pointers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i] <= 32'd0;
                fifo_data_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r[PTR_W-1:0]] <= cfg_addr;
                fifo_data_r[wr_ptr_r[PTR_W-1:0]] <= cfg_wdata;
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end
        end
    end

    // Clear-pending flag and sweep index; re-requests while pending are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clear_pend_r <= 1'b0;
            sweep_idx_r  <= '0;
        end else begin
            if (clear_acc_s) begin
                clear_pend_r <= 1'b1;
            end else if (sweep_done_s) begin
                clear_pend_r <= 1'b0;
            end
            if (sweep_done_s) begin
                sweep_idx_r <= '0;
            end else if (sweep_wr_s) begin
                sweep_idx_r <= sweep_idx_r + IDX_W'(1);
            end
        end
    end

    // Registered table write port; address/data hold when no write issues.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sasa_wen_r  <= 1'b0;
            sasa_addr_r <= 32'd0;
            sasa_data_r <= 32'd0;
        end else begin
            sasa_wen_r <= pop_s || sweep_wr_s;
            if (pop_s) begin
                sasa_addr_r <= fifo_addr_r[rd_ptr_r[PTR_W-1:0]];
                sasa_data_r <= fifo_data_r[rd_ptr_r[PTR_W-1:0]];
            end else if (sweep_wr_s) begin
                sasa_addr_r <= sweep_addr_s;
                sasa_data_r <= 32'd0;
            end
        end
    end

endmodule

// File: doc/sparce_sasa_cfg_ctrl.md
Name: sparce_sasa_cfg_ctrl

Overview:
- Configuration sequencer for the SparCE SASA table.
- Accepts software config writes (CSR/MMIO store path), buffers them in a small FIFO, and replays them onto the table write port (sasa_addr/sasa_data/sasa_wen) one per cycle.
- Writes are deferred while the PSRU is skipping, so table contents never change mid-skip.
- Also provides a hardware clear sweep that invalidates every table entry.

Parameters:
- FIFO_DEPTH, 4: config write buffer depth; power of 2, minimum 2.
- NUM_ENTRIES, 16: number of SASA table entries swept by clear.
- SASA_BASE, 32'h0000_1000: byte address of entry 0, word 0.
- ENTRY_STRIDE, 8: bytes per entry. Word 0 is preceding_pc; word 1 (+4) is the config word. A config word of 0 marks the entry invalid.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- cfg_wen  in  1  config write request
- cfg_addr  in  32  config byte address
- cfg_wdata  in  32  config data
- cfg_ready  out  1  write accepted this cycle when cfg_wen & cfg_ready
- clear_req  in  1  single-cycle pulse; request a full-table invalidate
- clear_busy  out  1  clear pending or in progress
- skipping  in  1  PSRU skip in progress; stalls table writes
- sasa_wen  out  1  table write enable (registered)
- sasa_addr  out  32  table write address (registered)
- sasa_data  out  32  table write data (registered)
- idle  out  1  FIFO empty, no clear pending, FSM in IDLE
- cfg_err  out  1  sticky address error (see Optional Feature)

Behaviour:
- Reset (async, RST=1): FIFO empty, pointers 0, FSM=IDLE, clear_pend=0, sweep counter 0. Outputs: sasa_wen=0, sasa_addr=0, sasa_data=0, cfg_err=0, clear_busy=0, idle=1, cfg_ready=1.
- Reset mid-operation discards all buffered writes and any sweep; the table is not touched after reset deasserts.
- FIFO entry is {addr, data}.
- cfg_ready = !full & !clear_pend.
  - Push when cfg_wen & cfg_ready.
  - When full, no push occurs even if a pop happens in the same cycle (ready derives from registered full).
  - Push and pop in the same cycle when not full: occupancy unchanged.
- FSM states:
  - IDLE:
    - If clear_pend & FIFO empty -> CLEAR.
    - Else if FIFO not empty -> DRAIN.
  - DRAIN:
    - Each cycle with skipping=0 and FIFO not empty: pop the head; next cycle sasa_wen=1 with the popped addr/data.
    - skipping=1: no pop; sasa_wen=0 next cycle; addr/data hold their last values.
    - FIFO empty: go to CLEAR if clear_pend, else IDLE.
  - CLEAR:
    - Each cycle with skipping=0: write sasa_addr = SASA_BASE + i*ENTRY_STRIDE + 4, sasa_data=0; i increments 0..NUM_ENTRIES-1.
    - skipping=1 pauses the sweep without incrementing i.
    - After entry NUM_ENTRIES-1 is written: clear_pend=0, i=0, go to IDLE.
- Clear request handling:
  - clear_req sets clear_pend (blocking new writes). Writes already buffered drain first; the clear then follows.
  - clear_req while already pending or in CLEAR is ignored; the sweep does not restart.
  - clear_busy = clear_pend.
- Latency: a write accepted at cycle N with an empty FIFO and skipping=0 appears as sasa_wen=1 at cycle N+2 (push at N, pop at N+1, registered output at N+2).
- Throughput: 1 table write/cycle.
- sasa_wen is never high for more than one cycle per FIFO entry or sweep index.
- Ordering: table writes occur in exactly the order they were accepted. No merging or dropping (except under the Optional Feature).
- idle = FIFO empty & !clear_pend & FSM==IDLE & sasa_wen==0.

Optional Feature:
Macro SPARCE_CFG_ADDR_CHECK_EN.
- Defined: on push, a write is checked. It is invalid if cfg_addr[1:0]!=0, or cfg_addr < SASA_BASE, or cfg_addr >= SASA_BASE + NUM_ENTRIES*ENTRY_STRIDE.
  - An invalid write is still acknowledged (cfg_ready) but is not pushed.
  - cfg_err is set and stays 1 until clear_req is accepted.
- Undefined: no check; every accepted write is forwarded; cfg_err is tied 0.

Test Plan:
- Reset, then a single write addr=0x1004 data=0xA5A5_0001, skipping=0 -> sasa_wen=1 two cycles later with the same addr/data; idle returns to 1.
- Five back-to-back writes with skipping=1 held, FIFO_DEPTH=4 -> cfg_ready=0 after 4 accepts; release skipping -> 4 writes on consecutive cycles, in order; then the 5th write is accepted.
- 2 writes queued, then a clear_req pulse -> cfg_ready=0; both writes issue first, then 16 writes to 0x1004,0x100C,...,0x107C with data 0; clear_busy falls after the last write.
- Assert skipping for 3 cycles at sweep index 5 -> no sasa_wen during the stall; sweep resumes at 0x102C; no index skipped or repeated.
- Assert RST mid-sweep at index 7 -> all outputs take reset values immediately; no further table writes after release.
- With SPARCE_CFG_ADDR_CHECK_EN: write addr=0x1002 -> no sasa_wen, cfg_err=1; a clear_req then clears cfg_err.
